pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch unit for the iCEPIC baseline core. It drives the program-memory read port and holds the instruction register (IR) that feeds `inst_dec`. It also consumes the decoder's PC-update, jump-address and stack push/pop outputs to choose the next fetch address. It implements the two-stage fetch/execute pipeline, branch/skip flush (bubble insertion) and the hardware return stack.

## Interface
Parameters:
- `STACK_DEPTH`, 2, return-stack levels (≥1).
- `RESET_VECTOR`, 12'h000, first fetch address after reset.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_update_sel_in`  in  `pc_update_sel_t`  decoder PC source for the instruction in IR.
- `jump_addr_in`  in  12  decoder jump target.
- `stack_push_in`  in  1  decoder CALL indication.
- `stack_pop_in`  in  1  decoder RETLW indication.
- `skip_in`  in  1  executing instruction's skip condition is true (BTFSC/BTFSS/DECFSZ/INCFSZ).
- `page_in`  in  2  STATUS page bits, used for PCL writes.
- `pcl_in`  in  8  ALU result written to PCL.
- `pmem_rd_out`  out  1  program-memory read request.
- `pmem_addr_out`  out  12  program-memory address.
- `pmem_data_in`  in  12  program-memory read data.
- `pmem_valid_in`  in  1  read data valid; completes the current access.
- `inst_out`  out  `inst_t`  IR contents to the decoder.
- `inst_pc_out`  out  12  address of `inst_out`.
- `exec_en_out`  out  1  IR holds a real instruction (0 = bubble).
- `retire_out`  out  1  one-cycle strobe; the instruction in IR completes this cycle.

## Operation
- Registers: `fetch_pc`, `ir`, `ir_pc`, `ir_valid`, `stack[STACK_DEPTH]`, state.
- State machine:
  - S_IDLE, entered on reset: `pmem_rd_out`=0. The first clock edge after reset release moves to S_FETCH.
  - S_FETCH: `pmem_rd_out`=1 and `pmem_addr_out`=`fetch_pc`. No exit except reset.
- Step event: S_FETCH && `pmem_valid_in`. Nothing advances between steps, and decoder inputs must stay stable.
- At each step with `ir_valid`=1, `retire_out`=1. Next-state rules are applied in priority order:
  1. JUMP: `fetch_pc`←`jump_addr_in`. The fetched word is discarded and IR becomes a bubble.
  2. RET: `fetch_pc`←`stack[0]`, then pop. Bubble.
  3. PCL_MOD: `fetch_pc`←{1'b0,`page_in`,1'b0,`pcl_in`}. Bubble.
  4. `skip_in`: `fetch_pc`←`fetch_pc`+1. Bubble.
  5. INC: IR←`pmem_data_in`, `ir_pc`←`fetch_pc`, `ir_valid`←1, `fetch_pc`←`fetch_pc`+1.
- At a step with `ir_valid`=0, rule 5 always applies. All decoder inputs and `skip_in` are ignored.
- Bubble means `ir`←12'h000 (NOP) and `ir_valid`←0.
- `stack_push_in` at a retiring step:
  - `stack[i+1]`←`stack[i]`; `stack[0]`←`ir_pc`+1.
  - When the stack is full, the bottom entry is lost.
- Pop:
  - `stack[i]`←`stack[i+1]`; the bottom entry keeps its value.
  - Popping an empty stack returns stale contents, with no error.
- A simultaneous push and pop is illegal from the decoder. If it occurs, pop wins.
- Arithmetic is 12-bit modulo: 12'hFFF+1 = 12'h000.

## Timing
- Reset values:
  - `pmem_rd_out`=0, `pmem_addr_out`=`RESET_VECTOR`.
  - `inst_out`=12'h000, `inst_pc_out`=0, `exec_en_out`=0, `retire_out`=0.
  - Stack all 0; `stack_err_out`=0 when the feature is compiled in.
- The first request is asserted 1 cycle after reset release.
- `pmem_addr_out` is registered and held stable until `pmem_valid_in`. The next address appears the cycle after the step.
- `retire_out` is combinational: (step && `ir_valid`).
- With zero-wait memory (`pmem_valid_in` tied 1), throughput is one instruction per cycle. Each branch or skip costs exactly one bubble.
- Asserting `rst` mid-access aborts the access immediately. A late `pmem_valid_in` arriving during S_IDLE is ignored.

## Configuration
- `PC_FETCH_STACK_ERR_EN` defined:
  - Adds output `stack_err_out` (1 bit), a sticky flag plus an occupancy counter.
  - The flag sets on a push while occupancy equals `STACK_DEPTH`, or on a pop while occupancy is 0.
  - Only `rst` clears it.
- Not defined: the port and counter are absent, and overflow/underflow are silent as described above.

## Test plan
- Reset and first fetch:
  - During reset, `pmem_rd_out`=0 and `exec_en_out`=0.
  - 1 cycle after release: `pmem_rd_out`=1, addr 12'h000.
- Sequential run with memory valid after 3 wait cycles:
  - `pmem_addr_out` is held stable for 3 cycles.
  - `inst_pc_out` steps 000, 001, 002.
  - `retire_out` pulses once per step.
- GOTO at 0x003 with `jump_addr_in`=0x050:
  - The word from 0x004 is discarded, and `exec_en_out`=0 for one step.
  - The next address is 0x050.
- Calls with `STACK_DEPTH`=2:
  - CALL at 0x010, 0x020 and 0x030 pushes 0x011, 0x021, 0x031.
  - Three RETLWs then fetch 0x031, 0x021, 0x021.
  - With `PC_FETCH_STACK_ERR_EN`, `stack_err_out` goes 1 at the third CALL.
- `skip_in`=1 at retire of 0x005: the 0x006 word is bubbled and the next fetch is 0x007.
- PCL_MOD with `page_in`=2'b01 and `pcl_in`=0x34: the next fetch address is 0x234.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Shared types and the decoder/program-memory bundle of the pc_fetch unit.
// Build with PC_FETCH_STACK_ERR_EN defined to add the stack_err_out flag.
package pc_fetch_pkg;
  typedef enum logic [1:0] {
    PC_INC     = 2'd0,
    PC_JUMP    = 2'd1,
    PC_RET     = 2'd2,
    PC_PCL_MOD = 2'd3
  } pc_update_sel_t;

  typedef logic [11:0] inst_t;
endpackage

interface pc_fetch_if;
  import pc_fetch_pkg::*;

  pc_update_sel_t pc_update_sel_in;
  logic [11:0]    jump_addr_in;
  logic           stack_push_in;
  logic           stack_pop_in;
  logic           skip_in;
  logic [1:0]     page_in;
  logic [7:0]     pcl_in;
  logic           pmem_rd_out;
  logic [11:0]    pmem_addr_out;
  logic [11:0]    pmem_data_in;
  logic           pmem_valid_in;
  inst_t          inst_out;
  logic [11:0]    inst_pc_out;
  logic           exec_en_out;
  logic           retire_out;
`ifdef PC_FETCH_STACK_ERR_EN
  logic           stack_err_out;
`endif

  modport master (
    input  pc_update_sel_in, jump_addr_in, stack_push_in, stack_pop_in,
    input  skip_in, page_in, pcl_in, pmem_data_in, pmem_valid_in,
`ifdef PC_FETCH_STACK_ERR_EN
    output stack_err_out,
`endif
    output pmem_rd_out, pmem_addr_out, inst_out, inst_pc_out,
    output exec_en_out, retire_out
  );

  modport slave (
    output pc_update_sel_in, jump_addr_in, stack_push_in, stack_pop_in,
    output skip_in, page_in, pcl_in, pmem_data_in, pmem_valid_in,
`ifdef PC_FETCH_STACK_ERR_EN
    input  stack_err_out,
`endif
    input  pmem_rd_out, pmem_addr_out, inst_out, inst_pc_out,
    input  exec_en_out, retire_out
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter, instruction register and return stack for the iCEPIC core.
// PC_FETCH_STACK_ERR_EN adds a sticky stack over/underflow flag.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int          STACK_DEPTH  = 2,
  parameter logic [11:0] RESET_VECTOR = 12'h000
) (
  input logic       clk,
  input logic       rst,
  pc_fetch_if.master bus
);
  // state   | meaning
  // S_IDLE  | after reset, no memory request
  // S_FETCH | read request outstanding at r_fetch_pc
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  logic [0:0]  r_state;
  logic [11:0] r_fetch_pc;
  inst_t       r_ir;
  logic [11:0] r_ir_pc;
  logic        r_ir_valid;
  logic [11:0] r_stack [STACK_DEPTH];

  logic        w_step;
  logic        w_push;
  logic        w_pop;
  logic        w_bubble;
  logic [11:0] w_next_pc;

  assign w_step = (r_state == S_FETCH) && bus.pmem_valid_in;

  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_bubble  = 1'b0;
    w_next_pc = r_fetch_pc + 12'd1;
    // Decoder and skip inputs only matter while IR holds a real instruction.
    if (r_ir_valid) begin
      w_pop  = bus.stack_pop_in;
      w_push = bus.stack_push_in && !bus.stack_pop_in;
      case (bus.pc_update_sel_in)
        PC_JUMP: begin
          w_next_pc = bus.jump_addr_in;
          w_bubble  = 1'b1;
        end
        PC_RET: begin
          w_next_pc = r_stack[0];
          w_bubble  = 1'b1;
        end
        PC_PCL_MOD: begin
          w_next_pc = {1'b0, bus.page_in, 1'b0, bus.pcl_in};
          w_bubble  = 1'b1;
        end
        default: w_bubble = bus.skip_in;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_VECTOR;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      if (r_state == S_IDLE) r_state <= S_FETCH;
      if (w_step) begin
        r_fetch_pc <= w_next_pc;
        if (w_bubble) begin
          r_ir       <= '0;
          r_ir_valid <= 1'b0;
        end else begin
          r_ir       <= bus.pmem_data_in;
          r_ir_pc    <= r_fetch_pc;
          r_ir_valid <= 1'b1;
        end
        if (w_pop) begin
          for (int i = 0; i < STACK_DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
        end else if (w_push) begin
          for (int i = STACK_DEPTH - 1; i > 0; i--) r_stack[i] <= r_stack[i-1];
          r_stack[0] <= r_ir_pc + 12'd1;
        end
      end
    end
  end

`ifdef PC_FETCH_STACK_ERR_EN
  localparam int OCC_W = $clog2(STACK_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STACK_DEPTH);

  logic [OCC_W-1:0] r_occ;
  logic             r_stack_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ       <= '0;
      r_stack_err <= 1'b0;
    end else if (w_step) begin
      if (w_pop) begin
        if (r_occ == '0) r_stack_err <= 1'b1;
        else             r_occ <= r_occ - 1'b1;
      end else if (w_push) begin
        if (r_occ == OCC_FULL) r_stack_err <= 1'b1;
        else                   r_occ <= r_occ + 1'b1;
      end
    end
  end

  assign bus.stack_err_out = r_stack_err;
`endif

  assign bus.pmem_rd_out   = (r_state == S_FETCH);
  assign bus.pmem_addr_out = r_fetch_pc;
  assign bus.inst_out      = r_ir;
  assign bus.inst_pc_out   = r_ir_pc;
  assign bus.exec_en_out   = r_ir_valid;
  assign bus.retire_out    = w_step && r_ir_valid;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, wait states, jumps, skip, PCL writes,
// return stack with overflow, PC wraparound and mid-access reset.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  logic [11:0] cur_addr;

  pc_fetch_if bus ();

  pc_fetch #(.STACK_DEPTH(2), .RESET_VECTOR(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] f_word(input logic [11:0] a);
    return a ^ 12'hA5C;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dec(input pc_update_sel_t sel, input logic [11:0] ja,
                     input logic push, input logic pop, input logic skip,
                     input logic [1:0] pg, input logic [7:0] pcl);
    bus.pc_update_sel_in = sel;
    bus.jump_addr_in     = ja;
    bus.stack_push_in    = push;
    bus.stack_pop_in     = pop;
    bus.skip_in          = skip;
    bus.page_in          = pg;
    bus.pcl_in           = pcl;
  endtask

  task automatic dec_clear();
    dec(PC_INC, 12'h000, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  // One memory access: waits idle cycles then a valid cycle, then checks IR state.
  task automatic step(input int waits, input logic exp_ret, input logic [11:0] exp_addr,
                      input logic [11:0] exp_pc, input logic exp_valid);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("rd_wait", {11'd0, bus.pmem_rd_out}, 12'd1);
      chk("addr_hold", bus.pmem_addr_out, cur_addr);
      chk("retire_wait", {11'd0, bus.retire_out}, 12'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.pmem_valid_in = 1'b1;
    bus.pmem_data_in  = f_word(bus.pmem_addr_out);
    #1;
    chk("addr_at_step", bus.pmem_addr_out, cur_addr);
    chk("retire", {11'd0, bus.retire_out}, {11'd0, exp_ret});
    @(posedge clk);
    #1;
    bus.pmem_valid_in = 1'b0;
    dec_clear();
    chk("next_addr", bus.pmem_addr_out, exp_addr);
    chk("inst_pc", bus.inst_pc_out, exp_pc);
    chk("exec_en", {11'd0, bus.exec_en_out}, {11'd0, exp_valid});
    chk("inst", bus.inst_out, exp_valid ? f_word(exp_pc) : 12'h000);
    cur_addr = exp_addr;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cur_addr = 12'h000;
    rst = 1'b1;
    bus.pmem_valid_in = 1'b0;
    bus.pmem_data_in  = 12'h000;
    dec_clear();

    repeat (2) @(negedge clk);
    chk("rst_rd", {11'd0, bus.pmem_rd_out}, 12'd0);
    chk("rst_addr", bus.pmem_addr_out, 12'h000);
    chk("rst_exec", {11'd0, bus.exec_en_out}, 12'd0);
    chk("rst_inst", bus.inst_out, 12'h000);
    chk("rst_inst_pc", bus.inst_pc_out, 12'h000);
    chk("rst_retire", {11'd0, bus.retire_out}, 12'd0);
`ifdef PC_FETCH_STACK_ERR_EN
    chk("rst_stack_err", {11'd0, bus.stack_err_out}, 12'd0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_rd", {11'd0, bus.pmem_rd_out}, 12'd0);
    @(posedge clk);
    #1;
    chk("first_rd", {11'd0, bus.pmem_rd_out}, 12'd1);
    chk("first_addr", bus.pmem_addr_out, 12'h000);

    // Sequential fetch with three wait states.
    step(3, 1'b0, 12'h001, 12'h000, 1'b1);
    step(3, 1'b1, 12'h002, 12'h001, 1'b1);
    step(3, 1'b1, 12'h003, 12'h002, 1'b1);
    step(0, 1'b1, 12'h004, 12'h003, 1'b1);
    // GOTO 0x050 at 0x003; bubble step ignores decoder and skip.
    dec(PC_JUMP, 12'h050, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h050, 12'h003, 1'b0);
    dec(PC_JUMP, 12'h777, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    step(1, 1'b0, 12'h051, 12'h050, 1'b1);
    // Back to 0x005 and skip the 0x006 word.
    dec(PC_JUMP, 12'h005, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h005, 12'h050, 1'b0);
    step(0, 1'b0, 12'h006, 12'h005, 1'b1);
    dec(PC_INC, 12'h000, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    step(0, 1'b1, 12'h007, 12'h005, 1'b0);
    step(2, 1'b0, 12'h008, 12'h007, 1'b1);
    // PCL write with page 01.
    dec(PC_PCL_MOD, 12'h000, 1'b0, 1'b0, 1'b0, 2'b01, 8'h34);
    step(0, 1'b1, 12'h234, 12'h007, 1'b0);
    step(0, 1'b0, 12'h235, 12'h234, 1'b1);
    // Three nested calls overflow a two-level stack.
    dec(PC_JUMP, 12'h010, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h010, 12'h234, 1'b0);
    step(0, 1'b0, 12'h011, 12'h010, 1'b1);
    dec(PC_JUMP, 12'h020, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h020, 12'h010, 1'b0);
    step(0, 1'b0, 12'h021, 12'h020, 1'b1);
    dec(PC_JUMP, 12'h030, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h030, 12'h020, 1'b0);
`ifdef PC_FETCH_STACK_ERR_EN
    chk("stack_err_2calls", {11'd0, bus.stack_err_out}, 12'd0);
`endif
    step(0, 1'b0, 12'h031, 12'h030, 1'b1);
    dec(PC_JUMP, 12'h100, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h100, 12'h030, 1'b0);
`ifdef PC_FETCH_STACK_ERR_EN
    chk("stack_err_3calls", {11'd0, bus.stack_err_out}, 12'd1);
`endif
    step(0, 1'b0, 12'h101, 12'h100, 1'b1);
    // Three returns: 0x031, 0x021, then the stale bottom entry 0x021.
    dec(PC_RET, 12'h000, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h031, 12'h100, 1'b0);
    step(0, 1'b0, 12'h032, 12'h031, 1'b1);
    dec(PC_RET, 12'h000, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h021, 12'h031, 1'b0);
    step(0, 1'b0, 12'h022, 12'h021, 1'b1);
    dec(PC_RET, 12'h000, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'h021, 12'h021, 1'b0);
    step(0, 1'b0, 12'h022, 12'h021, 1'b1);
    // Wraparound at 0xFFF.
    dec(PC_JUMP, 12'hFFF, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    step(0, 1'b1, 12'hFFF, 12'h021, 1'b0);
    step(0, 1'b0, 12'h000, 12'hFFF, 1'b1);
    step(0, 1'b1, 12'h001, 12'h000, 1'b1);

    // Reset in the middle of an access, then a late valid while idle.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rd", {11'd0, bus.pmem_rd_out}, 12'd0);
    chk("midrst_addr", bus.pmem_addr_out, 12'h000);
    chk("midrst_exec", {11'd0, bus.exec_en_out}, 12'd0);
    chk("midrst_inst_pc", bus.inst_pc_out, 12'h000);
`ifdef PC_FETCH_STACK_ERR_EN
    chk("midrst_stack_err", {11'd0, bus.stack_err_out}, 12'd0);
`endif
    bus.pmem_valid_in = 1'b1;
    bus.pmem_data_in  = 12'h3C3;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("late_valid_retire", {11'd0, bus.retire_out}, 12'd0);
    @(posedge clk);
    #1;
    bus.pmem_valid_in = 1'b0;
    chk("post_rst_rd", {11'd0, bus.pmem_rd_out}, 12'd1);
    chk("post_rst_addr", bus.pmem_addr_out, 12'h000);
    chk("post_rst_exec", {11'd0, bus.exec_en_out}, 12'd0);
    cur_addr = 12'h000;
    step(0, 1'b0, 12'h001, 12'h000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
